// File: rtl/sd_block_arbiter.sv
// sd_block_arbiter: shares the single hps_io SD block channel between NREQ
// virtual-drive requesters, granted round-robin.
//
// Ports:
//   clk_sys, reset_n            clock, async active-low reset
//   req_valid/req_write/req_lba per-requester block request (held until req_ready)
//   req_ready                   one-cycle accept pulse to the granted requester
//   done/err                    one-cycle completion pulse (err coincident with done)
//   sd_lba/sd_rd/sd_wr          request side of hps_io SD channel
//   sd_ack/sd_buff_wr           acknowledge and per-byte strobe from hps_io
//   busy                        high whenever not idle (including post-reset sync)
//   cur_id                      index of the requester currently being served
//
// Optional feature: define SD_TIMEOUT_EN to add a TIMEOUT_CYC watchdog over the
// ISSUE and XFER phases; on expiry the operation completes with err and the
// arbiter resynchronises to sd_ack low.
module sd_block_arbiter #(
    parameter int unsigned NREQ        = 3,
    parameter int unsigned IDW         = 2,
    parameter logic [23:0] TIMEOUT_CYC = 24'hFFFFFF
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_write,
    input  logic [32*NREQ-1:0]   req_lba,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic [31:0]          sd_lba,
    output logic [NREQ-1:0]      sd_rd,
    output logic [NREQ-1:0]      sd_wr,
    input  logic                 sd_ack,
    input  logic                 sd_buff_wr,
    output logic                 busy,
    output logic [IDW-1:0]       cur_id
);

    typedef enum logic [2:0] {StSync, StIdle, StIssue, StXfer, StDone} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  last_grant_q;
    logic [IDW-1:0]  id_q;
    logic            wr_q;
    logic [31:0]     sd_lba_q;
    logic [NREQ-1:0] sd_rd_q, sd_wr_q, req_ready_q;
    logic [9:0]      byte_cnt_q;

    logic            pick_found;
    logic [IDW-1:0]  pick_id, idx;
    logic [NREQ-1:0] pick_oh, id_oh;
    logic [31:0]     pick_lba;
    logic            pick_wr;
    logic            err_cond;

`ifdef SD_TIMEOUT_EN
    logic [23:0]     tmo_cnt_q;
    logic            tmo_q;
    logic            tmo_hit;
    assign tmo_hit = ((state_q == StIssue) || (state_q == StXfer)) && (tmo_cnt_q == TIMEOUT_CYC);
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
`endif

    // Round-robin search starting one past the last served requester.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            idx = IDW'((int'(last_grant_q) + k) % int'(NREQ));
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = idx;
            end
        end
        pick_oh  = '0;
        pick_lba = '0;
        pick_wr  = 1'b0;
        id_oh    = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (pick_id == IDW'(i)) begin
                pick_oh[i] = pick_found;
                pick_lba   = req_lba[32*i +: 32];
                pick_wr    = req_write[i];
            end
            if (id_q == IDW'(i)) begin
                id_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSync:  if (!sd_ack)   state_d = StIdle;
            StIdle:  if (pick_found) state_d = StIssue;
            StIssue: if (sd_ack)    state_d = StXfer;
            StXfer:  if (!sd_ack)   state_d = StDone;
            StDone:                 state_d = StIdle;
            default:                state_d = StSync;
        endcase
`ifdef SD_TIMEOUT_EN
        if (tmo_hit) state_d = StDone;
        // A timed-out transfer may still be live on hps_io; wait for ack to drop.
        if ((state_q == StDone) && tmo_q) state_d = StSync;
`endif
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StSync;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= IDW'(NREQ - 1);
            id_q         <= '0;
            wr_q         <= 1'b0;
            sd_lba_q     <= '0;
            sd_rd_q      <= '0;
            sd_wr_q      <= '0;
            req_ready_q  <= '0;
            byte_cnt_q   <= '0;
`ifdef SD_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            tmo_q        <= 1'b0;
`endif
        end else begin
            req_ready_q <= '0;
            if ((state_q == StIdle) && pick_found) begin
                id_q        <= pick_id;
                wr_q        <= pick_wr;
                sd_lba_q    <= pick_lba;
                req_ready_q <= pick_oh;
                sd_rd_q     <= pick_wr ? '0 : pick_oh;
                sd_wr_q     <= pick_wr ? pick_oh : '0;
            end
            if ((state_q == StIssue) && sd_ack) begin
                sd_rd_q    <= '0;
                sd_wr_q    <= '0;
                byte_cnt_q <= '0;
            end
            if ((state_q == StXfer) && sd_buff_wr && (byte_cnt_q != 10'h3FF)) begin
                byte_cnt_q <= byte_cnt_q + 10'd1;
            end
            if (state_q == StDone) begin
                last_grant_q <= id_q;
            end
`ifdef SD_TIMEOUT_EN
            if ((state_q == StIssue) || (state_q == StXfer)) begin
                tmo_cnt_q <= tmo_cnt_q + 24'd1;
            end else begin
                tmo_cnt_q <= '0;
            end
            if (tmo_hit) begin
                sd_rd_q <= '0;
                sd_wr_q <= '0;
                tmo_q   <= 1'b1;
            end
            if (state_q == StDone) begin
                tmo_q <= 1'b0;
            end
`endif
        end
    end

`ifdef SD_TIMEOUT_EN
    assign err_cond = tmo_q || (!wr_q && (byte_cnt_q != 10'd512));
`else
    assign err_cond = !wr_q && (byte_cnt_q != 10'd512);
`endif

    assign done      = (state_q == StDone) ? id_oh : '0;
    assign err       = ((state_q == StDone) && err_cond) ? id_oh : '0;
    assign req_ready = req_ready_q;
    assign sd_lba    = sd_lba_q;
    assign sd_rd     = sd_rd_q;
    assign sd_wr     = sd_wr_q;
    assign busy      = (state_q != StIdle);
    assign cur_id    = id_q;

endmodule
